// File: rtl/crc_engine.sv
// crc_engine: serial MSB-first CRC/LFSR engine.
// Accepts DATA_W-bit words over a valid/ready handshake and folds one bit per
// clock into a CRC_W-bit register. When the word flagged as last has been
// absorbed, crc_out is updated and crc_valid pulses for one cycle.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | waiting for a word, in_ready high unless clear is asserted
// S_SHIFT | folding the latched word into crc, one bit per edge
// S_DONE  | crc_out holds the finished checksum, crc_valid high, crc reloads
module crc_engine #(
  parameter int               CRC_W  = 16,
  parameter int               DATA_W = 8,
  parameter logic [CRC_W-1:0] POLY   = 16'h1021,
  parameter logic [CRC_W-1:0] INIT   = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              busy,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_valid
);

  // The counter needs at least one bit so DATA_W=1 still has a legal register.
  localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CRC_W-1:0]   crc;
  logic [CRC_W-1:0]   crc_shift;
  logic [DATA_W-1:0]  sh;
  logic [CNT_W-1:0]   cnt;
  logic               last_q;
  logic               fb;
  logic               cnt_zero;

  // Feedback step, handshake/status outputs and next-state selection.
  always_comb begin
    state_nxt = state;
    fb        = crc[CRC_W-1] ^ sh[DATA_W-1];
    crc_shift = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    cnt_zero  = (cnt == '0);
    in_ready  = (state == S_IDLE) & ~clear;
    busy      = (state != S_IDLE);
    crc_valid = (state == S_DONE);

    if (clear) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (in_valid) state_nxt = S_SHIFT;
        S_SHIFT: if (cnt_zero) state_nxt = last_q ? S_DONE : S_IDLE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: word capture, bit-serial CRC update and result capture.
  // crc carries across non-last words so a message can span many words;
  // only DONE, clear and rst bring it back to INIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc     <= INIT;
      sh      <= '0;
      cnt     <= '0;
      last_q  <= 1'b0;
      crc_out <= '0;
    end else if (clear) begin
      crc    <= INIT;
      sh     <= '0;
      cnt    <= '0;
      last_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sh     <= in_data;
            cnt    <= CNT_LOAD;
            last_q <= in_last;
          end
        end
        S_SHIFT: begin
          crc <= crc_shift;
          sh  <= sh << 1;
          if (!cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
          end else if (last_q) begin
            crc_out <= crc_shift;
          end
        end
        S_DONE: begin
          crc    <= INIT;
          last_q <= 1'b0;
        end
        default: begin
          crc <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_engine.sv
// tb_crc_engine: table-driven check of crc_engine (DATA_W=8) plus hand-written
// sequences for reset, clear, stall and DATA_W=16 width equivalence.
module tb_crc_engine;

  logic        clk;
  logic        rst;
  logic        clear;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  in_data8;
  logic        in_last8;
  logic        busy8;
  logic [15:0] crc_out8;
  logic        crc_valid8;

  logic        in_valid16;
  logic        in_ready16;
  logic [15:0] in_data16;
  logic        in_last16;
  logic        busy16;
  logic [15:0] crc_out16;
  logic        crc_valid16;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int vcnt8 = 0;

  typedef struct packed {
    logic [3:0]  n;
    logic [71:0] d;
    logic [15:0] exp;
    logic [2:0]  gap;
    logic        tog;
  } vec_t;

  vec_t vecs [7];

  crc_engine #(.CRC_W(16), .DATA_W(8), .POLY(16'h1021), .INIT(16'hFFFF)) dut8 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_last(in_last8),
    .busy(busy8), .crc_out(crc_out8), .crc_valid(crc_valid8)
  );

  crc_engine #(.CRC_W(16), .DATA_W(16), .POLY(16'h1021), .INIT(16'hFFFF)) dut16 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16), .in_last(in_last16),
    .busy(busy16), .crc_out(crc_out16), .crc_valid(crc_valid16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (crc_valid8) vcnt8++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Bit-serial reference CRC-16 (poly 0x1021, init 0xFFFF), bytes taken from the top of d.
  function automatic logic [15:0] crc_ref(input logic [71:0] d, input int n);
    logic [15:0] c;
    logic [7:0]  b;
    logic        f;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      b = d[71-8*i -: 8];
      for (int j = 7; j >= 0; j--) begin
        f = c[15] ^ b[j];
        c = {c[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timeout waiting on DUT", name);
  endtask

  // Called at a negedge; returns at the negedge after the final accept edge.
  task automatic send8(input logic [71:0] d, input int n, input bit do_last, input int gap_max,
                       input bit tog, input bit chk_space, input string name, output int acc);
    int prev;
    int t;
    int g;
    prev = -1;
    acc  = 0;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (!in_ready8 && t < 40) begin
        @(negedge clk);
        t++;
      end
      if (t >= 40) begin
        timeout({name, " ready"});
        return;
      end
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      if (g > 0) begin
        in_valid8 = 1'b0;
        repeat (g) begin
          @(negedge clk);
          if (tog) begin
            in_data8 = 8'($urandom);
            in_last8 = 1'($urandom);
          end
        end
      end
      in_valid8 = 1'b1;
      in_data8  = d[71-8*k -: 8];
      in_last8  = do_last && (k == n - 1);
      acc = cyc + 1;
      if (chk_space && prev >= 0) chk({name, " accept spacing"}, 32'(acc - prev), 32'd9);
      prev = acc;
      @(posedge clk);
      #1;
      if (k == n - 1) in_valid8 = 1'b0;
      if (tog) begin
        in_data8 = ~in_data8;
        in_last8 = ~in_last8;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_crc8(input logic [15:0] exp, input int acc, input string name);
    int t;
    t = 0;
    while (!crc_valid8 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) begin
      timeout({name, " crc_valid"});
      return;
    end
    chk({name, " crc_out"}, 32'(crc_out8), 32'(exp));
    chk({name, " valid latency"}, 32'(cyc - acc), 32'd8);
    @(negedge clk);
    chk({name, " valid pulse width"}, 32'(crc_valid8), 32'd0);
    chk({name, " crc_out held"}, 32'(crc_out8), 32'(exp));
  endtask

  initial begin
    int acc;
    int t;
    int v0;
    int prev16;
    logic [71:0] msg;
    logic [15:0] exp1234;

    msg     = 72'h313233343536373839;
    exp1234 = crc_ref(72'h313233340000000000, 4);

    vecs[0] = '{n: 4'd9, d: msg, exp: 16'h29B1, gap: 3'd0, tog: 1'b0};
    vecs[1] = '{n: 4'd1, d: 72'h0, exp: 16'hE1F0, gap: 3'd0, tog: 1'b0};
    vecs[2] = '{n: 4'd1, d: 72'h0, exp: 16'hE1F0, gap: 3'd0, tog: 1'b0};
    vecs[3] = '{n: 4'd1, d: 72'hFF0000000000000000, exp: 16'hFF00, gap: 3'd0, tog: 1'b0};
    vecs[4] = '{n: 4'd4, d: 72'h313233340000000000, exp: exp1234, gap: 3'd0, tog: 1'b0};
    vecs[5] = '{n: 4'd9, d: msg, exp: 16'h29B1, gap: 3'd5, tog: 1'b1};
    vecs[6] = '{n: 4'd2, d: 72'hA55A00000000000000,
                exp: crc_ref(72'hA55A00000000000000, 2), gap: 3'd2, tog: 1'b1};

    rst = 1'b1;
    clear = 1'b0;
    in_valid8 = 1'b0;  in_data8 = '0;  in_last8 = 1'b0;
    in_valid16 = 1'b0; in_data16 = '0; in_last16 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset in_ready", 32'(in_ready8), 32'd1);
    chk("reset busy", 32'(busy8), 32'd0);
    chk("reset crc_valid", 32'(crc_valid8), 32'd0);
    chk("reset crc_out", 32'(crc_out8), 32'd0);
    chk("reset crc_out16", 32'(crc_out16), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      send8(vecs[i].d, int'(vecs[i].n), 1'b1, int'(vecs[i].gap), vecs[i].tog,
            vecs[i].gap == 0, $sformatf("vec%0d", i), acc);
      wait_crc8(vecs[i].exp, acc, $sformatf("vec%0d", i));
    end

    // rst in the middle of SHIFT: outputs return to reset values at once.
    in_valid8 = 1'b1; in_data8 = 8'h31; in_last8 = 1'b0;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-rst busy", 32'(busy8), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid rst busy", 32'(busy8), 32'd0);
    chk("mid rst in_ready", 32'(in_ready8), 32'd1);
    chk("mid rst crc_valid", 32'(crc_valid8), 32'd0);
    chk("mid rst crc_out", 32'(crc_out8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post rst in_ready", 32'(in_ready8), 32'd1);
    send8(msg, 9, 1'b1, 0, 1'b0, 1'b1, "after rst", acc);
    wait_crc8(16'h29B1, acc, "after rst");

    // clear during SHIFT of the 5th byte aborts the message silently.
    v0 = vcnt8;
    send8(msg, 5, 1'b0, 0, 1'b0, 1'b0, "abort", acc);
    @(negedge clk);
    chk("abort busy before clear", 32'(busy8), 32'd1);
    clear = 1'b1;
    #1;
    chk("clear in_ready", 32'(in_ready8), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("clear busy", 32'(busy8), 32'd0);
    chk("clear in_ready after", 32'(in_ready8), 32'd1);
    chk("clear keeps crc_out", 32'(crc_out8), 32'h29B1);
    @(negedge clk);
    send8(msg, 9, 1'b1, 0, 1'b0, 1'b1, "after clear", acc);
    wait_crc8(16'h29B1, acc, "after clear");
    #1;
    chk("clear valid count", 32'(vcnt8 - v0), 32'd1);

    // clear together with in_valid in IDLE: the word is not taken.
    @(negedge clk);
    v0 = vcnt8;
    clear = 1'b1; in_valid8 = 1'b1; in_data8 = 8'hFF; in_last8 = 1'b1;
    #1;
    chk("clear+valid in_ready", 32'(in_ready8), 32'd0);
    @(negedge clk);
    clear = 1'b0; in_valid8 = 1'b0;
    #1;
    chk("clear+valid busy", 32'(busy8), 32'd0);
    repeat (12) @(negedge clk);
    #1;
    chk("clear+valid no pulse", 32'(vcnt8 - v0), 32'd0);
    @(negedge clk);
    send8(72'h0, 1, 1'b1, 0, 1'b0, 1'b0, "post clear+valid", acc);
    wait_crc8(16'hE1F0, acc, "post clear+valid");

    // DATA_W=16: two words match the four-byte DATA_W=8 result.
    in_valid16 = 1'b1; in_data16 = 16'h3132; in_last16 = 1'b0;
    chk("w16 ready first", 32'(in_ready16), 32'd1);
    prev16 = cyc + 1;
    @(posedge clk); #1;
    in_data16 = 16'h3334; in_last16 = 1'b1;
    @(negedge clk);
    t = 0;
    while (!in_ready16 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) begin
      timeout("w16 ready");
    end else begin
      acc = cyc + 1;
      chk("w16 accept spacing", 32'(acc - prev16), 32'd17);
      @(posedge clk); #1;
      in_valid16 = 1'b0; in_data16 = 16'hDEAD; in_last16 = 1'b0;
      @(negedge clk);
      t = 0;
      while (!crc_valid16 && t < 60) begin
        @(negedge clk);
        t++;
      end
      if (t >= 60) begin
        timeout("w16 crc_valid");
      end else begin
        chk("w16 crc_out", 32'(crc_out16), 32'(exp1234));
        chk("w16 valid latency", 32'(cyc - acc), 32'd16);
        @(negedge clk);
        chk("w16 pulse width", 32'(crc_valid16), 32'd0);
        chk("w16 busy after", 32'(busy16), 32'd0);
      end
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
